ysyx_22040237_wbu: RTL and testbench
====================================

YSYX_22040237_WBU -- requirements
Module: ysyx_22040237_wbu

Interface
REQ-001 Parameter: REG_WIDTH, default 64, GPR data width; equals the shared register-width constant.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 exu_valid_i  in  1  EXU result valid.
REQ-005 exu_ready_o  out  1  WBU can accept EXU result.
REQ-006 exu_pc_i  in  64  PC of the instruction.
REQ-007 exu_rd_wen_i  in  1  instruction writes rd.
REQ-008 exu_rd_idx_i  in  5  destination register index.
REQ-009 exu_result_i  in  REG_WIDTH  ALU result; for loads, bits [2:0] are the byte address offset.
REQ-010 exu_is_load_i  in  1  instruction is a load.
REQ-011 exu_ld_funct3_i  in  3  load funct3.
REQ-012 lsu_rvalid_i  in  1  load data valid, one-cycle pulse.
REQ-013 lsu_rdata_i  in  64  naturally aligned 64-bit memory doubleword.
REQ-014 rd_wr_en_o  out  1  register-file write enable.
REQ-015 rd_wr_idx_o  out  5  register-file write index.
REQ-016 rd_wr_data_o  out  REG_WIDTH  register-file write data.
REQ-017 commit_valid_o  out  1  one-cycle instruction-retire pulse for simulation.
REQ-018 commit_pc_o  out  64  PC of the retiring instruction.
REQ-019 pend_valid_o  out  1  a load with rd!=0 awaits data (hazard scoreboard).
REQ-020 pend_idx_o  out  5  rd of the pending load.

Function
REQ-021 FSM states: IDLE, WAIT_LOAD.
REQ-022 exu_ready_o = 1 in IDLE, 0 in WAIT_LOAD.
REQ-023 Handshake: a transfer occurs when exu_valid_i && exu_ready_o; fields are sampled only at that edge.
REQ-024 Non-load transfer in IDLE: next cycle rd_wr_data_o = exu_result_i, commit_valid_o = 1; latency 1; back-to-back throughput 1/cycle.
REQ-025 Load transfer in IDLE: capture pc, rd, wen, funct3, offset = exu_result_i[2:0]; go to WAIT_LOAD; no commit.
REQ-026 WAIT_LOAD: on lsu_rvalid_i, next cycle write the formatted data, pulse commit, return to IDLE; hold state indefinitely without rvalid.
REQ-027 lsu_rvalid_i in IDLE is ignored.
REQ-028 Format: effective offset = offset masked to the access size (LH/LHU clear bit0; LW/LWU clear bits1:0; LD uses 0); extract the byte/half/word at that offset.
REQ-029 funct3 000 LB / 001 LH / 010 LW sign-extend; 100 LBU / 101 LHU / 110 LWU zero-extend; 011 LD is unmodified; 111 writes 0 and still commits.
REQ-030 rd_wr_en_o = commit pulse && wen && rd != 0; rd x0 and wen=0 still commit.
REQ-031 rd_wr_en_o, idx, data, commit_valid_o, and commit_pc_o are registered; rd_wr_en_o and commit_valid_o are high exactly one cycle per retire; idx, data, and pc hold their last values otherwise.
REQ-032 pend_valid_o = (state == WAIT_LOAD) && wen && rd != 0; pend_idx_o = captured rd; it deasserts in the same cycle rd_wr_en_o rises.

Reset
REQ-033 rst low asynchronously forces IDLE and all outputs to 0 except exu_ready_o, which goes to 1 once rst is released.
REQ-034 Reset during WAIT_LOAD discards the load: no write, no commit; a later stray lsu_rvalid_i is ignored.

Structure
REQ-035 The shared package holds REG_WIDTH, the FSM state encoding, and the load funct3 constants.
REQ-036 One combinational sub-module, ysyx_22040237_ld_fmt (funct3, offset, rdata -> data), performs the load extraction.

Verification
REQ-037 ADDI result 0x5, rd=3, pc 0x80000000 -> next cycle wr_en=1, idx=3, data=0x5, commit pc 0x80000000.
REQ-038 LB, offset 3, rdata 0x00000000_80FF0000 -> data 0xFFFF_FFFF_FFFF_FF80 (byte 3 = 0x80, sign-extended); exu_ready_o=0 and pend_valid_o=1 until rvalid.
REQ-039 LHU, offset 5 (masked to 4), rdata 0xBEEF1234_00000000 -> data 0x1234.
REQ-040 Three back-to-back non-loads with rd=0, 7, 8 -> three commits; wr_en pattern 0, 1, 1.
REQ-041 Load in flight, rst asserted, released, then lsu_rvalid_i pulse -> no write, no commit, state IDLE.
REQ-042 funct3 111 load with rd=9 -> write 0 to x9, commit pulses.

Source files
------------

// File: rtl/ysyx_22040237_wbu_pkg.sv
// ysyx_22040237_wbu_pkg: shared width, FSM encoding and load funct3 codes for the write-back unit
package ysyx_22040237_wbu_pkg;
    localparam int REG_WIDTH = 64;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } wbu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
endpackage

// File: rtl/ysyx_22040237_ld_fmt.sv
// ysyx_22040237_ld_fmt: extracts and extends a load result from an aligned doubleword
module ysyx_22040237_ld_fmt
    import ysyx_22040237_wbu_pkg::*;
#(
    parameter int REG_WIDTH = ysyx_22040237_wbu_pkg::REG_WIDTH
) (
    input  logic [2:0]           funct3,
    input  logic [2:0]           offset,
    input  logic [63:0]          rdata,
    output logic [REG_WIDTH-1:0] data
);
    logic [2:0]  eff_off;
    logic [63:0] shifted;
    logic [63:0] full;

    // offset is trimmed to the access size so misaligned low bits never shift the field
    assign eff_off = (funct3[1:0] == 2'b01) ? {offset[2:1], 1'b0} :
                     (funct3[1:0] == 2'b10) ? {offset[2], 2'b00} :
                     (funct3[1:0] == 2'b11) ? 3'b000 : offset;
    assign shifted = rdata >> {eff_off, 3'b000};
    assign full = (funct3 == F3_LB)  ? {{56{shifted[7]}}, shifted[7:0]} :
                  (funct3 == F3_LH)  ? {{48{shifted[15]}}, shifted[15:0]} :
                  (funct3 == F3_LW)  ? {{32{shifted[31]}}, shifted[31:0]} :
                  (funct3 == F3_LD)  ? rdata :
                  (funct3 == F3_LBU) ? {56'd0, shifted[7:0]} :
                  (funct3 == F3_LHU) ? {48'd0, shifted[15:0]} :
                  (funct3 == F3_LWU) ? {32'd0, shifted[31:0]} : 64'd0;
    assign data = full[REG_WIDTH-1:0];
endmodule

// File: rtl/ysyx_22040237_wbu.sv
// ysyx_22040237_wbu: write-back unit; retires EXU results and waits for load data before writing rd
module ysyx_22040237_wbu
    import ysyx_22040237_wbu_pkg::*;
#(
    parameter int REG_WIDTH = ysyx_22040237_wbu_pkg::REG_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 exu_valid_i,
    output logic                 exu_ready_o,
    input  logic [63:0]          exu_pc_i,
    input  logic                 exu_rd_wen_i,
    input  logic [4:0]           exu_rd_idx_i,
    input  logic [REG_WIDTH-1:0] exu_result_i,
    input  logic                 exu_is_load_i,
    input  logic [2:0]           exu_ld_funct3_i,
    input  logic                 lsu_rvalid_i,
    input  logic [63:0]          lsu_rdata_i,
    output logic                 rd_wr_en_o,
    output logic [4:0]           rd_wr_idx_o,
    output logic [REG_WIDTH-1:0] rd_wr_data_o,
    output logic                 commit_valid_o,
    output logic [63:0]          commit_pc_o,
    output logic                 pend_valid_o,
    output logic [4:0]           pend_idx_o
);
    wbu_state_e state, state_nxt;
    logic [63:0]          ld_pc;
    logic [4:0]           ld_rd;
    logic                 ld_wen;
    logic [2:0]           ld_f3;
    logic [2:0]           ld_off;
    logic [REG_WIDTH-1:0] ld_data;
    logic                 fire;
    logic                 ld_done;

    assign fire        = exu_valid_i && exu_ready_o;
    assign ld_done     = (state == WAIT_LOAD) && lsu_rvalid_i;
    // ready is held low while reset is asserted
    assign exu_ready_o = rst && (state == IDLE);
    assign pend_valid_o = (state == WAIT_LOAD) && ld_wen && (ld_rd != 5'd0);
    assign pend_idx_o  = ld_rd;

    always_comb begin
        state_nxt = state;
        if (state == IDLE && fire && exu_is_load_i) state_nxt = WAIT_LOAD;
        if (ld_done) state_nxt = IDLE;
    end

    ysyx_22040237_ld_fmt #(.REG_WIDTH(REG_WIDTH)) u_ld_fmt (
        .funct3 (ld_f3),
        .offset (ld_off),
        .rdata  (lsu_rdata_i),
        .data   (ld_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            ld_pc          <= '0;
            ld_rd          <= '0;
            ld_wen         <= 1'b0;
            ld_f3          <= '0;
            ld_off         <= '0;
            rd_wr_en_o     <= 1'b0;
            rd_wr_idx_o    <= '0;
            rd_wr_data_o   <= '0;
            commit_valid_o <= 1'b0;
            commit_pc_o    <= '0;
        end else begin
            state          <= state_nxt;
            rd_wr_en_o     <= 1'b0;
            commit_valid_o <= 1'b0;
            if (fire && exu_is_load_i) begin
                ld_pc  <= exu_pc_i;
                ld_rd  <= exu_rd_idx_i;
                ld_wen <= exu_rd_wen_i;
                ld_f3  <= exu_ld_funct3_i;
                ld_off <= exu_result_i[2:0];
            end else if (fire) begin
                rd_wr_en_o     <= exu_rd_wen_i && (exu_rd_idx_i != 5'd0);
                rd_wr_idx_o    <= exu_rd_idx_i;
                rd_wr_data_o   <= exu_result_i;
                commit_valid_o <= 1'b1;
                commit_pc_o    <= exu_pc_i;
            end else if (ld_done) begin
                rd_wr_en_o     <= ld_wen && (ld_rd != 5'd0);
                rd_wr_idx_o    <= ld_rd;
                rd_wr_data_o   <= ld_data;
                commit_valid_o <= 1'b1;
                commit_pc_o    <= ld_pc;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_22040237_wbu.sv
// tb_ysyx_22040237_wbu: directed vectors with hand-computed expectations for the write-back unit
module tb_ysyx_22040237_wbu;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        exu_valid_i = 1'b0;
    logic        exu_ready_o;
    logic [63:0] exu_pc_i = '0;
    logic        exu_rd_wen_i = 1'b0;
    logic [4:0]  exu_rd_idx_i = '0;
    logic [63:0] exu_result_i = '0;
    logic        exu_is_load_i = 1'b0;
    logic [2:0]  exu_ld_funct3_i = '0;
    logic        lsu_rvalid_i = 1'b0;
    logic [63:0] lsu_rdata_i = '0;
    logic        rd_wr_en_o;
    logic [4:0]  rd_wr_idx_o;
    logic [63:0] rd_wr_data_o;
    logic        commit_valid_o;
    logic [63:0] commit_pc_o;
    logic        pend_valid_o;
    logic [4:0]  pend_idx_o;
    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ysyx_22040237_wbu dut (
        .clk             (clk),
        .rst             (rst),
        .exu_valid_i     (exu_valid_i),
        .exu_ready_o     (exu_ready_o),
        .exu_pc_i        (exu_pc_i),
        .exu_rd_wen_i    (exu_rd_wen_i),
        .exu_rd_idx_i    (exu_rd_idx_i),
        .exu_result_i    (exu_result_i),
        .exu_is_load_i   (exu_is_load_i),
        .exu_ld_funct3_i (exu_ld_funct3_i),
        .lsu_rvalid_i    (lsu_rvalid_i),
        .lsu_rdata_i     (lsu_rdata_i),
        .rd_wr_en_o      (rd_wr_en_o),
        .rd_wr_idx_o     (rd_wr_idx_o),
        .rd_wr_data_o    (rd_wr_data_o),
        .commit_valid_o  (commit_valid_o),
        .commit_pc_o     (commit_pc_o),
        .pend_valid_o    (pend_valid_o),
        .pend_idx_o      (pend_idx_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic ld, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [63:0] res, input logic [63:0] pc);
        exu_valid_i = 1'b1;
        exu_is_load_i = ld;
        exu_ld_funct3_i = f3;
        exu_rd_wen_i = 1'b1;
        exu_rd_idx_i = rd;
        exu_result_i = res;
        exu_pc_i = pc;
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [2:0] off,
                           input logic [4:0] rd, input logic [63:0] rdata, input logic [63:0] exp);
        logic [63:0] pc;
        pc = 64'h8000_1000 + {56'd0, rd, off};
        issue(1'b1, f3, rd, {61'h200, off}, pc);
        step();
        exu_valid_i = 1'b0;
        chk({tag, "_ready"}, {63'd0, exu_ready_o}, 64'd0);
        chk({tag, "_pend"}, {63'd0, pend_valid_o}, {63'd0, rd != 5'd0});
        chk({tag, "_pidx"}, {59'd0, pend_idx_o}, {59'd0, rd});
        chk({tag, "_nocommit"}, {63'd0, commit_valid_o}, 64'd0);
        step();
        step();
        chk({tag, "_hold"}, {63'd0, exu_ready_o}, 64'd0);
        lsu_rvalid_i = 1'b1;
        lsu_rdata_i = rdata;
        step();
        lsu_rvalid_i = 1'b0;
        lsu_rdata_i = 64'hDEAD_BEEF_DEAD_BEEF;
        chk({tag, "_data"}, rd_wr_data_o, exp);
        chk({tag, "_wen"}, {63'd0, rd_wr_en_o}, {63'd0, rd != 5'd0});
        chk({tag, "_idx"}, {59'd0, rd_wr_idx_o}, {59'd0, rd});
        chk({tag, "_commit"}, {63'd0, commit_valid_o}, 64'd1);
        chk({tag, "_cpc"}, commit_pc_o, pc);
        chk({tag, "_pend_off"}, {63'd0, pend_valid_o}, 64'd0);
        chk({tag, "_ready_back"}, {63'd0, exu_ready_o}, 64'd1);
        step();
    endtask

    initial begin
        #2;
        chk("rst_wen", {63'd0, rd_wr_en_o}, 64'd0);
        chk("rst_commit", {63'd0, commit_valid_o}, 64'd0);
        chk("rst_ready", {63'd0, exu_ready_o}, 64'd0);
        chk("rst_pend", {63'd0, pend_valid_o}, 64'd0);
        chk("rst_data", rd_wr_data_o, 64'd0);
        step();
        rst = 1'b1;
        step();
        chk("ready_after_rst", {63'd0, exu_ready_o}, 64'd1);

        issue(1'b0, 3'b000, 5'd3, 64'h5, 64'h8000_0000);
        step();
        exu_valid_i = 1'b0;
        chk("addi_wen", {63'd0, rd_wr_en_o}, 64'd1);
        chk("addi_idx", {59'd0, rd_wr_idx_o}, 64'd3);
        chk("addi_data", rd_wr_data_o, 64'h5);
        chk("addi_commit", {63'd0, commit_valid_o}, 64'd1);
        chk("addi_cpc", commit_pc_o, 64'h8000_0000);
        step();
        chk("addi_wen_drop", {63'd0, rd_wr_en_o}, 64'd0);
        chk("addi_commit_drop", {63'd0, commit_valid_o}, 64'd0);
        chk("addi_data_hold", rd_wr_data_o, 64'h5);

        do_load("lb",  3'b000, 3'd3, 5'd5,  64'h0000_0000_80FF_0000, 64'hFFFF_FFFF_FFFF_FF80);
        do_load("lhu", 3'b101, 3'd5, 5'd6,  64'hBEEF_1234_0000_0000, 64'h0000_0000_0000_1234);
        do_load("lw",  3'b010, 3'd6, 5'd11, 64'h8000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001);
        do_load("ld",  3'b011, 3'd5, 5'd12, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
        do_load("lbu", 3'b100, 3'd7, 5'd13, 64'hA500_0000_0000_0000, 64'h0000_0000_0000_00A5);
        do_load("lh",  3'b001, 3'd3, 5'd14, 64'h0000_0000_8001_0000, 64'hFFFF_FFFF_FFFF_8001);
        do_load("lwu", 3'b110, 3'd3, 5'd15, 64'h0000_0000_F000_0001, 64'h0000_0000_F000_0001);
        do_load("f7",  3'b111, 3'd0, 5'd9,  64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
        do_load("lb_x0", 3'b000, 3'd0, 5'd0, 64'h0000_0000_0000_0042, 64'h42);

        lsu_rvalid_i = 1'b1;
        step();
        lsu_rvalid_i = 1'b0;
        chk("idle_rvalid_commit", {63'd0, commit_valid_o}, 64'd0);
        chk("idle_rvalid_ready", {63'd0, exu_ready_o}, 64'd1);

        issue(1'b0, 3'b000, 5'd0, 64'h11, 64'h8000_0100);
        step();
        chk("b2b0_commit", {63'd0, commit_valid_o}, 64'd1);
        chk("b2b0_wen", {63'd0, rd_wr_en_o}, 64'd0);
        issue(1'b0, 3'b000, 5'd7, 64'h22, 64'h8000_0104);
        step();
        chk("b2b1_commit", {63'd0, commit_valid_o}, 64'd1);
        chk("b2b1_wen", {63'd0, rd_wr_en_o}, 64'd1);
        chk("b2b1_data", rd_wr_data_o, 64'h22);
        issue(1'b0, 3'b000, 5'd8, 64'h33, 64'h8000_0108);
        step();
        exu_valid_i = 1'b0;
        chk("b2b2_commit", {63'd0, commit_valid_o}, 64'd1);
        chk("b2b2_wen", {63'd0, rd_wr_en_o}, 64'd1);
        chk("b2b2_idx", {59'd0, rd_wr_idx_o}, 64'd8);
        chk("b2b2_cpc", commit_pc_o, 64'h8000_0108);

        issue(1'b0, 3'b000, 5'd4, 64'h44, 64'h8000_0200);
        exu_rd_wen_i = 1'b0;
        step();
        exu_valid_i = 1'b0;
        chk("nowen_commit", {63'd0, commit_valid_o}, 64'd1);
        chk("nowen_wen", {63'd0, rd_wr_en_o}, 64'd0);

        issue(1'b1, 3'b011, 5'd10, 64'h8, 64'h8000_0300);
        step();
        exu_valid_i = 1'b0;
        chk("rstld_pend", {63'd0, pend_valid_o}, 64'd1);
        #3;
        rst = 1'b0;
        #1;
        chk("rstld_pend_clr", {63'd0, pend_valid_o}, 64'd0);
        chk("rstld_ready_low", {63'd0, exu_ready_o}, 64'd0);
        step();
        rst = 1'b1;
        step();
        lsu_rvalid_i = 1'b1;
        lsu_rdata_i = 64'h1234;
        step();
        lsu_rvalid_i = 1'b0;
        chk("rstld_commit", {63'd0, commit_valid_o}, 64'd0);
        chk("rstld_wen", {63'd0, rd_wr_en_o}, 64'd0);
        chk("rstld_ready", {63'd0, exu_ready_o}, 64'd1);
        chk("rstld_data", rd_wr_data_o, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
